read_empty_fwft: RTL and testbench

// Read-side controller of the dual-clock async FIFO; counterpart of the write-pointer/full stage.

---
 rtl/read_empty_fwft_if.sv | 24 ++
 rtl/read_empty_fwft.sv | 190 +++++++++++++++++++
 tb/tb_read_empty_fwft.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/read_empty_fwft_if.sv
// Output stream of the FIFO read side: head-of-FIFO word with a valid/ready handshake.
//   dout       - head word, held stable while dout_valid & !dout_ready
//   dout_valid - dout carries a valid word
//   dout_ready - consumer accepts; a pop happens on dout_valid & dout_ready
// master: the FIFO read controller. slave: the consumer.
interface read_empty_fwft_if #(
    parameter int unsigned DATA_SIZE = 8
) ();
    logic [DATA_SIZE-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/read_empty_fwft.sv
// Read-side controller of a dual-clock async FIFO.
// Synchronises the write-domain gray pointer into rclk, maintains the read binary/gray pointers,
// produces registered empty / almost-empty / level flags, and prefetches words from a
// synchronous-read dual-port RAM into a 2-entry first-word-fall-through output buffer.
// Ports:
//   rclk, rreset_n   - read clock, asynchronous active-low reset
//   wptr_i           - write pointer (gray, wclk domain)
//   rptr_o           - read pointer (gray, registered) for the write-domain full logic
//   raddr_o, ren_o   - RAM read address (registered) and read enable
//   mem_rdata_i      - RAM read data, valid the cycle after ren_o
//   rempty_o         - no unfetched word in RAM
//   ralmost_empty_o  - rlevel_o <= AE_THRESH
//   rlevel_o         - unfetched words in RAM (output buffer not included)
//   out_if           - output stream (dout / dout_valid / dout_ready)
module read_empty_fwft #(
    parameter int unsigned ADDRESS_SIZE = 4,
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AE_THRESH    = 1
) (
    input  logic                    rclk,
    input  logic                    rreset_n,
    input  logic [ADDRESS_SIZE:0]   wptr_i,
    output logic [ADDRESS_SIZE:0]   rptr_o,
    output logic [ADDRESS_SIZE-1:0] raddr_o,
    output logic                    ren_o,
    input  logic [DATA_SIZE-1:0]    mem_rdata_i,
    output logic                    rempty_o,
    output logic                    ralmost_empty_o,
    output logic [ADDRESS_SIZE:0]   rlevel_o,
    read_empty_fwft_if.master       out_if
);

    localparam int unsigned PtrW = ADDRESS_SIZE + 1;
    typedef logic [PtrW-1:0] ptr_t;

    localparam ptr_t AeThresh = ptr_t'(AE_THRESH);

    // ------------------------------------------------------------------
    // Write-pointer synchroniser
    // ------------------------------------------------------------------
    ptr_t sync_q [SYNC_STAGES];
    ptr_t wq;
    ptr_t wbin_s;

    always_ff @(posedge rclk or negedge rreset_n) begin
        if (!rreset_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all gray bits at or above i.
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i < int'(PtrW); i++) begin
            wbin_s[i] = ^(wq >> i);
        end
    end

    // ------------------------------------------------------------------
    // Read pointer and flags
    // ------------------------------------------------------------------
    ptr_t                    rbin_q;
    ptr_t                    rptr_q;
    logic [ADDRESS_SIZE-1:0] raddr_q;
    logic                    rempty_q;
    logic                    ralmost_empty_q;
    ptr_t                    rlevel_q;

    ptr_t rbin_next;
    ptr_t rgray_next;
    ptr_t level_next;

    // Output buffer state
    logic [DATA_SIZE-1:0] head_q, head_d;
    logic [DATA_SIZE-1:0] skid_q, skid_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q;

    logic       pop;
    logic       ren;
    logic [2:0] pending;

    assign pop = (occ_q != 2'd0) & out_if.dout_ready;

    // Words that will sit in the buffer after this edge if nothing new is fetched. A fetch is only
    // issued when that leaves room for the word arriving one cycle later.
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign ren     = !rempty_q && (pending < 3'd2);

    assign rbin_next  = rbin_q + ptr_t'(ren);
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;
    // Level is measured against the synchronised (stale) write pointer, so it can only understate.
    assign level_next = wbin_s - rbin_next;

    always_ff @(posedge rclk or negedge rreset_n) begin
        if (!rreset_n) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            raddr_q         <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rlevel_q        <= '0;
        end else begin
            rbin_q          <= rbin_next;
            rptr_q          <= rgray_next;
            raddr_q         <= rbin_next[ADDRESS_SIZE-1:0];
            rempty_q        <= (rgray_next == wq);
            ralmost_empty_q <= (level_next <= AeThresh);
            rlevel_q        <= level_next;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry FWFT output buffer: head is what the consumer sees, skid catches the word that
    // was already in flight when the consumer stalled.
    // ------------------------------------------------------------------
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = mem_rdata_i;
                    occ_d  = 2'd1;
                end else begin
                    skid_d = mem_rdata_i;
                    occ_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = skid_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Pop and arrival together: occupancy unchanged, no bubble.
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = mem_rdata_i;
                end else begin
                    head_d = mem_rdata_i;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rreset_n) begin
        if (!rreset_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            occ_q      <= occ_d;
            inflight_q <= ren;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rptr_o            = rptr_q;
    assign raddr_o           = raddr_q;
    assign ren_o             = ren;
    assign rempty_o          = rempty_q;
    assign ralmost_empty_o   = ralmost_empty_q;
    assign rlevel_o          = rlevel_q;
    assign out_if.dout       = head_q;
    assign out_if.dout_valid = (occ_q != 2'd0);

    // Buffer must never be asked to hold a third word.
    a_no_overflow: assert property (@(posedge rclk) disable iff (!rreset_n)
        !(inflight_q && !pop && (occ_q == 2'd2)));
    a_occ_range: assert property (@(posedge rclk) disable iff (!rreset_n) occ_q <= 2'd2);

endmodule

// File: tb/tb_read_empty_fwft.sv
module tb_read_empty_fwft;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned AE = 1;

    logic          rclk = 1'b0;
    logic          rreset_n = 1'b0;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] mem_rdata;
    logic          rempty;
    logic          rae;
    logic [AW:0]   rlevel;

    read_empty_fwft_if #(.DATA_SIZE(DW)) bus ();

    read_empty_fwft #(
        .ADDRESS_SIZE(AW),
        .DATA_SIZE   (DW),
        .SYNC_STAGES (SS),
        .AE_THRESH   (AE)
    ) dut (
        .rclk           (rclk),
        .rreset_n       (rreset_n),
        .wptr_i         (wptr),
        .rptr_o         (rptr),
        .raddr_o        (raddr),
        .ren_o          (ren),
        .mem_rdata_i    (mem_rdata),
        .rempty_o       (rempty),
        .ralmost_empty_o(rae),
        .rlevel_o       (rlevel),
        .out_if         (bus)
    );

    always #5 rclk = ~rclk;

    // Synchronous-read RAM model
    logic [DW-1:0] ram [16];
    always @(posedge rclk) begin
        if (ren) mem_rdata <= ram[raddr];
    end

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q [$];
    logic [AW-1:0] ren_addr_q [$];
    logic [AW:0]   wbin;
    int            pops, ren_cnt, tick_no, first_pop, last_pop, wraps, lat;
    bit            chk_gray;
    logic [AW:0]   prev_rptr;
    logic [AW-1:0] prev_raddr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW:0] b2g(input logic [AW:0] b);
        return (b >> 1) ^ b;
    endfunction

    // One cycle: drive ready at the falling edge, observe ren and any pop due at the next rise.
    task automatic tick(input bit rdy);
        @(negedge rclk);
        bus.dout_ready = rdy;
        #1;
        tick_no++;
        if (ren) begin
            ren_cnt++;
            ren_addr_q.push_back(raddr);
        end
        if (chk_gray) begin
            if (rptr != prev_rptr) check_eq("rptr_1bit", $countones(rptr ^ prev_rptr), 1);
            if (prev_raddr == 4'hF && raddr == 4'h0) wraps++;
        end
        prev_rptr  = rptr;
        prev_raddr = raddr;
        if (bus.dout_valid && bus.dout_ready) begin
            pops++;
            if (first_pop < 0) first_pop = tick_no;
            last_pop = tick_no;
            if (exp_q.size() == 0) check_eq("pop_q_empty", exp_q.size(), 1);
            else check_eq("data", bus.dout, exp_q.pop_front());
        end
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        ram[wbin[AW-1:0]] = d;
        wbin = wbin + 1'b1;
        wptr = b2g(wbin);
        exp_q.push_back(d);
    endtask

    task automatic assert_reset();
        @(negedge rclk);
        #2;
        rreset_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        wbin = '0;
        wptr = '0;
        exp_q.delete();
        ren_addr_q.delete();
        pops = 0;
        ren_cnt = 0;
        first_pop = -1;
        repeat (2) @(negedge rclk);
        rreset_n = 1'b1;
        prev_rptr = '0;
        prev_raddr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dout_ready = 1'b0;
        wptr = '0;
        wbin = '0;
        pops = 0;
        ren_cnt = 0;
        tick_no = 0;
        first_pop = -1;
        last_pop = 0;
        wraps = 0;
        chk_gray = 1'b0;
        prev_rptr = '0;
        prev_raddr = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        repeat (3) @(negedge rclk);
        rreset_n = 1'b1;

        // Reset state
        tick(1'b0);
        check_eq("rst_rempty", rempty, 1);
        check_eq("rst_ae", rae, 1);
        check_eq("rst_rlevel", rlevel, 0);
        check_eq("rst_rptr", rptr, 0);
        check_eq("rst_raddr", raddr, 0);
        check_eq("rst_valid", bus.dout_valid, 0);
        check_eq("rst_dout", bus.dout, 0);
        check_eq("rst_ren", ren, 0);

        // Single word: latency, one fetch, one pop
        write_word(8'hA5);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            tick(1'b1);
            if (pops > 0) lat = i;
        end
        check_eq("t2_latency", lat, SS + 3);
        repeat (4) tick(1'b1);
        check_eq("t2_pops", pops, 1);
        check_eq("t2_rens", ren_cnt, 1);
        if (ren_addr_q.size() > 0) check_eq("t2_raddr", ren_addr_q[0], 0);
        check_eq("t2_rptr", rptr, 5'b00001);
        check_eq("t2_rempty", rempty, 1);
        check_eq("t2_rlevel", rlevel, 0);
        check_eq("t2_valid", bus.dout_valid, 0);

        // Full RAM, consumer stalled: exactly two prefetches
        assert_reset();
        release_reset();
        for (int i = 0; i < 16; i++) write_word(8'(i * 37 + 3));
        check_eq("t3_wptr", wptr, 5'b11000);
        repeat (12) tick(1'b0);
        check_eq("t3_rens", ren_cnt, 2);
        if (ren_addr_q.size() == 2) begin
            check_eq("t3_raddr0", ren_addr_q[0], 0);
            check_eq("t3_raddr1", ren_addr_q[1], 1);
        end
        check_eq("t3_rlevel", rlevel, 14);
        check_eq("t3_rempty", rempty, 0);
        check_eq("t3_ae", rae, 0);
        check_eq("t3_valid", bus.dout_valid, 1);
        check_eq("t3_dout", bus.dout, 8'd3);
        check_eq("t3_pops", pops, 0);

        // Reset mid-stream with a full output buffer
        assert_reset();
        check_eq("t1_valid", bus.dout_valid, 0);
        check_eq("t1_rempty", rempty, 1);
        check_eq("t1_rptr", rptr, 0);
        check_eq("t1_raddr", raddr, 0);
        check_eq("t1_rlevel", rlevel, 0);
        check_eq("t1_dout", bus.dout, 0);
        release_reset();

        // 16 words, random backpressure
        for (int i = 0; i < 16; i++) write_word(8'(8'hC0 ^ (i * 11)));
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick(1'($urandom_range(0, 1)));
        check_eq("t4_drained", exp_q.size(), 0);
        check_eq("t4_pops", pops, 16);
        repeat (4) tick(1'b1);
        check_eq("t4_rempty", rempty, 1);
        check_eq("t4_rlevel", rlevel, 0);
        check_eq("t4_valid", bus.dout_valid, 0);

        // 40-word stream with pointer wrap, ready held high
        pops = 0;
        first_pop = -1;
        wraps = 0;
        prev_rptr = rptr;
        prev_raddr = raddr;
        chk_gray = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1);
            write_word(8'(i * 3 + 1));
        end
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick(1'b1);
        repeat (3) tick(1'b1);
        chk_gray = 1'b0;
        check_eq("t5_drained", exp_q.size(), 0);
        check_eq("t5_pops", pops, 40);
        check_eq("t5_sustained", last_pop - first_pop + 1, 40);
        check_eq("t5_wraps", wraps, 2);
        check_eq("t5_rptr", rptr, b2g(wbin));

        // Almost-empty threshold and pop-with-fetch
        for (int i = 0; i < 5; i++) write_word(8'(8'h50 + i));
        repeat (10) tick(1'b0);
        check_eq("t6_rlevel3", rlevel, 3);
        check_eq("t6_ae3", rae, 0);
        check_eq("t6_valid3", bus.dout_valid, 1);
        tick(1'b1);
        tick(1'b1);
        check_eq("t6_rlevel2", rlevel, 2);
        check_eq("t6_ae2", rae, 0);
        check_eq("t6_valid2", bus.dout_valid, 1);
        tick(1'b1);
        check_eq("t6_rlevel1", rlevel, 1);
        check_eq("t6_ae1", rae, 1);
        check_eq("t6_valid1", bus.dout_valid, 1);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick(1'b1);
        repeat (3) tick(1'b1);
        check_eq("t6_drained", exp_q.size(), 0);
        check_eq("t6_rempty", rempty, 1);
        check_eq("t6_rlevel0", rlevel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
